// File: rtl/ram_1r1w_fifo_ctrl.sv
// rtl/ram_1r1w_fifo_ctrl.sv - FWFT FIFO controller in front of a 1R1W RAM macro
//
// Purpose: turns a bare 1R1W array with asynchronous read into a
// first-word-fall-through queue with valid/ready handshakes, occupancy,
// almost-full and synchronous flush. Storage stays in the RAM macro.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   flush_i                synchronous clear, wins over any traffic
//   enq_valid_i/_data_i    producer side; enq_ready_o = !full
//   deq_valid_o/_data_o    consumer side; deq_valid_o = !empty, data from RAM
//   deq_ready_i            consumer takes the head entry
//   count_o, almost_full_o occupancy and count_o >= AFULL_THRESH
//   ram_*                  RAM read/write address, write enable/data, read data
//   err_o                  sticky misuse flag (only with RAM_FIFO_ERR_CHECK_EN)
//
// Optional build macro: RAM_FIFO_ERR_CHECK_EN
module ram_1r1w_fifo_ctrl #(
  parameter int DEPTH        = 64,
  parameter int INDEX        = 6,
  parameter int WIDTH        = 32,
  parameter int AFULL_THRESH = 56
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  input  logic [WIDTH-1:0] enq_data_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [WIDTH-1:0] deq_data_o,
  input  logic             deq_ready_i,
  output logic [INDEX:0]   count_o,
  output logic             almost_full_o,
  output logic [INDEX-1:0] ram_raddr_o,
  output logic [INDEX-1:0] ram_waddr_o,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_wdata_o,
`ifdef RAM_FIFO_ERR_CHECK_EN
  output logic             err_o,
`endif
  input  logic [WIDTH-1:0] ram_rdata_i
);

  // DEPTH as a pointer-width value has only the wrap bit set, so full is
  // "pointers differ in exactly the wrap bit".
  localparam logic [INDEX:0] DEPTH_CNT = DEPTH[INDEX:0];
  localparam logic [INDEX:0] AFULL_CNT = AFULL_THRESH[INDEX:0];
  localparam logic [INDEX:0] ONE       = {{INDEX{1'b0}}, 1'b1};

  logic [INDEX:0] wr_ptr_q, wr_ptr_d;
  logic [INDEX:0] rd_ptr_q, rd_ptr_d;
  logic [INDEX:0] count_q, count_d;
  logic           empty, full;
  logic           enq_fire, deq_fire;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == DEPTH_CNT);

  assign enq_fire = enq_valid_i & ~full;
  assign deq_fire = deq_ready_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + ONE;
      if (deq_fire) rd_ptr_d = rd_ptr_q + ONE;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign enq_ready_o   = ~full;
  assign deq_valid_o   = ~empty;
  assign deq_data_o    = ram_rdata_i;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= AFULL_CNT);
  assign ram_raddr_o   = rd_ptr_q[INDEX-1:0];
  assign ram_waddr_o   = wr_ptr_q[INDEX-1:0];
  // A flushed push must not reach the array, and nothing is written while
  // reset is held even if the producer is asserting valid.
  assign ram_we_o      = enq_fire & ~flush_i & reset_n;
  assign ram_wdata_o   = enq_data_i;

`ifdef RAM_FIFO_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (flush_i) err_d = 1'b0;
    else if ((enq_valid_i & full) | (deq_ready_i & empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;

`ifndef SYNTHESIS
  logic [INDEX:0] ptr_diff;
  assign ptr_diff = wr_ptr_q - rd_ptr_q;

  always @(posedge clk) begin
    if (reset_n) begin
      assert (count_q == ptr_diff)
      else begin
        $display("ram_1r1w_fifo_ctrl: count %0d disagrees with pointer distance %0d",
                 count_q, ptr_diff);
        $error("ram_1r1w_fifo_ctrl count inconsistency");
      end
    end
  end
`endif
`endif

endmodule

// File: doc/ram_1r1w_fifo_ctrl.md
Name: ram_1r1w_fifo_ctrl

Overview:
- Queue controller that sits directly upstream of a 1R1W RAM macro. It drives the RAM's read address, write address, write enable and write data, and it consumes the RAM's asynchronous read data.
- Turns a bare 1R1W array into a first-word-fall-through FIFO with valid/ready handshakes, occupancy, almost-full and flush.
- Used for issue/load-store side queues where storage stays in the RAM macro.

Parameters:
DEPTH  64  number of entries; must be a power of two, minimum 2
INDEX  6  log2(DEPTH); RAM address width
WIDTH  32  entry data width
AFULL_THRESH  56  almost-full asserted when count >= this value; legal range 1..DEPTH

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous clear of the queue; highest priority after reset
enq_valid_i  in  1  producer has an entry
enq_data_i  in  WIDTH  entry to enqueue
enq_ready_o  out  1  queue can accept; equals !full
deq_valid_o  out  1  head entry is valid; equals !empty
deq_data_o  out  WIDTH  head entry; equals ram_rdata_i
deq_ready_i  in  1  consumer takes the head entry
count_o  out  INDEX+1  occupancy, 0..DEPTH
almost_full_o  out  1  count_o >= AFULL_THRESH
ram_raddr_o  out  INDEX  RAM read address = rd_ptr[INDEX-1:0]
ram_waddr_o  out  INDEX  RAM write address = wr_ptr[INDEX-1:0]
ram_we_o  out  1  RAM write enable = enq fire
ram_wdata_o  out  WIDTH  RAM write data = enq_data_i
ram_rdata_i  in  WIDTH  RAM asynchronous read data at ram_raddr_o

Behaviour:
- State:
  - wr_ptr and rd_ptr, each INDEX+1 bits; the MSB is the wrap bit.
  - count register, INDEX+1 bits.
- Empty/full:
  - empty = (wr_ptr == rd_ptr).
  - full = low INDEX bits equal and wrap bits differ.
  - count is maintained alongside the pointers and must always equal wr_ptr - rd_ptr mod 2^(INDEX+1).
- Handshakes:
  - enq_fire = enq_valid_i & !full.
  - deq_fire = deq_ready_i & !empty.
  - enq_ready_o and deq_valid_o depend only on registered state. There is no combinational path from either valid/ready input to either of these outputs.
- Enqueue:
  - On enq_fire, ram_we_o = 1 in the same cycle and the RAM writes at that clock edge.
  - wr_ptr increments by 1 and wraps naturally through its MSB.
- Dequeue:
  - deq_data_o is combinational from ram_rdata_i.
  - On deq_fire, rd_ptr increments, and the next head is visible the following cycle.
- Latency:
  - An entry enqueued into an empty queue at edge N has deq_valid_o = 1 in cycle N+1.
  - Dequeue and enqueue never bypass in the same cycle.
- Simultaneous enq_fire and deq_fire:
  - Both pointers advance and count is unchanged.
  - When full, enq_ready_o = 0 even if a dequeue is occurring in that cycle (no pass-through).
- Count update:
  - +1 on enq only, -1 on deq only, unchanged otherwise.
  - count_o never exceeds DEPTH and never underflows.
- Flush:
  - On flush_i = 1, wr_ptr, rd_ptr and count all go to 0 at the next edge.
  - Any concurrent enq/deq is discarded, but ram_we_o is still driven = 0 that cycle.
- Reset (reset_n = 0, asynchronous, including mid-operation):
  - Pointers = 0, count = 0.
  - Outputs: enq_ready_o = 1, deq_valid_o = 0, count_o = 0, almost_full_o = 0, ram_we_o = 0, ram_raddr_o = 0, ram_waddr_o = 0.
  - RAM contents are not cleared. deq_data_o is don't-care while deq_valid_o = 0.
- Wrap-around: after DEPTH pushes and DEPTH pops, both pointers return to index 0 with wrap bit = 1; empty is detected correctly.

Optional Feature:
- Macro: RAM_FIFO_ERR_CHECK_EN.
- When defined:
  - Adds output err_o (1 bit) plus a sticky error register, cleared by reset_n and by flush_i.
  - err_o sets the cycle after enq_valid_i = 1 while full, or deq_ready_i = 1 while empty.
  - Under simulation it also raises a $display and an assertion on count inconsistency with the pointers.
- When not defined:
  - Port err_o is absent, with no extra logic.
  - Push-while-full and pop-while-empty are silently ignored.

Test Plan:
- Reset mid-stream:
  - Stimulus: push 5 entries, then assert reset_n = 0 asynchronously between edges.
  - Required: count_o = 0, deq_valid_o = 0 and enq_ready_o = 1 immediately; the next push of 0xA5 is dequeued as 0xA5.
- Fill to full (DEPTH = 64):
  - Stimulus: push 0..63.
  - Required: enq_ready_o = 0 and count_o = 64; almost_full_o rises when count_o reaches 56.
  - Required: a 65th push is held off; pop order is 0..63.
- Simultaneous push/pop at half full:
  - Stimulus: from count 32, push and pop every cycle for 200 cycles.
  - Required: count_o stays at 32, data order is preserved and pointers wrap.
- Fall-through latency:
  - Stimulus: from empty, push 0xDEADBEEF at edge N.
  - Required: deq_valid_o = 1 and deq_data_o = 0xDEADBEEF in cycle N+1, not before.
- Flush with concurrent traffic:
  - Stimulus: at count 10, assert flush_i together with a push and a pop.
  - Required: next cycle count_o = 0, deq_valid_o = 0, and the pushed entry is not present.
- RAM_FIFO_ERR_CHECK_EN:
  - Stimulus: pop while empty.
  - Required: err_o = 1 the next cycle and it stays set; flush_i clears it.
